// File: rtl/fm_spy_capture.sv
// Spy-buffer capture engine: circular RAM that records monitor words with pre/post-trigger
// windowing, freezes on trigger completion or request, and serves frozen contents by index.
module fm_spy_capture #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk_hs,
    input  logic                  rst_hs,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    input  logic                  arm,
    input  logic                  trigger,
    input  logic                  freeze_req,
    input  logic [ADDR_WIDTH-1:0] post_count,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [1:0]            state,
    output logic                  triggered,
    output logic [ADDR_WIDTH-1:0] trig_index,
    output logic [ADDR_WIDTH:0]   fill_count
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ARMED  = 2'b01,
        S_POST   = 2'b10,
        S_FROZEN = 2'b11
    } state_t;

    state_t                st;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] trig_ptr;
    logic [ADDR_WIDTH-1:0] post_cnt;
    logic                  trig_pending;
    logic                  rd_pend;
    logic                  rd_zero;
    logic [ADDR_WIDTH-1:0] rd_phys;

    logic                  capture_c;
    logic                  wr_en_c;
    logic                  trig_word_c;
    logic [ADDR_WIDTH-1:0] wr_ptr_nxt_c;
    logic [ADDR_WIDTH:0]   fill_nxt_c;
    logic [ADDR_WIDTH-1:0] oldest_c;
    logic [ADDR_WIDTH-1:0] oldest_nxt_c;
    logic [ADDR_WIDTH-1:0] trig_ptr_eff_c;
    logic [ADDR_WIDTH-1:0] trig_index_nxt_c;
    logic [ADDR_WIDTH-1:0] rd_phys_c;
    logic                  rd_oob_c;

    assign state = st;

    // Write qualification, pointer arithmetic and trigger position relative to the oldest word
    always_comb begin
        capture_c        = (st == S_ARMED) || (st == S_POST);
        wr_en_c          = capture_c && data_valid && !freeze_req;
        trig_word_c      = wr_en_c && (((st == S_ARMED) && trigger) ||
                                       ((st == S_POST) && trig_pending));
        wr_ptr_nxt_c     = wr_ptr + ADDR_WIDTH'(1);
        fill_nxt_c       = (fill_count == FULL) ? fill_count
                                                : fill_count + (ADDR_WIDTH+1)'(1);
        oldest_c         = (fill_count == FULL) ? wr_ptr : '0;
        oldest_nxt_c     = (fill_nxt_c == FULL) ? wr_ptr_nxt_c : '0;
        trig_ptr_eff_c   = trig_word_c ? wr_ptr : trig_ptr;
        trig_index_nxt_c = trig_ptr_eff_c - oldest_nxt_c;
        rd_phys_c        = oldest_c + rd_addr;
        rd_oob_c         = ({1'b0, rd_addr} >= fill_count);
    end

    always_ff @(posedge clk_hs) begin
        if (wr_en_c) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Capture control; a trigger seen without data waits for the next valid word
    always_ff @(posedge clk_hs or negedge rst_hs) begin
        if (!rst_hs) begin
            st           <= S_IDLE;
            wr_ptr       <= '0;
            fill_count   <= '0;
            triggered    <= 1'b0;
            trig_index   <= '0;
            trig_ptr     <= '0;
            post_cnt     <= '0;
            trig_pending <= 1'b0;
        end else begin
            if (wr_en_c) begin
                wr_ptr     <= wr_ptr_nxt_c;
                fill_count <= fill_nxt_c;
            end
            if (trig_word_c) begin
                trig_ptr     <= wr_ptr;
                trig_pending <= 1'b0;
            end
            case (st)
                S_IDLE: begin
                    if (arm) begin
                        st <= S_ARMED;
                    end
                end
                S_ARMED, S_POST: begin
                    if (freeze_req) begin
                        st           <= S_FROZEN;
                        triggered    <= 1'b0;
                        trig_pending <= 1'b0;
                    end else if ((st == S_ARMED) && trigger) begin
                        post_cnt <= post_count;
                        if (!data_valid) begin
                            trig_pending <= 1'b1;
                            st           <= S_POST;
                        end else if (post_count == '0) begin
                            st         <= S_FROZEN;
                            triggered  <= 1'b1;
                            trig_index <= trig_index_nxt_c;
                        end else begin
                            st <= S_POST;
                        end
                    end else if ((st == S_POST) && data_valid) begin
                        if (trig_pending) begin
                            if (post_cnt == '0) begin
                                st         <= S_FROZEN;
                                triggered  <= 1'b1;
                                trig_index <= trig_index_nxt_c;
                            end
                        end else if (post_cnt == ADDR_WIDTH'(1)) begin
                            st         <= S_FROZEN;
                            triggered  <= 1'b1;
                            trig_index <= trig_index_nxt_c;
                        end else begin
                            post_cnt <= post_cnt - ADDR_WIDTH'(1);
                        end
                    end
                end
                S_FROZEN: begin
                    if (arm) begin
                        st         <= S_ARMED;
                        wr_ptr     <= '0;
                        fill_count <= '0;
                        triggered  <= 1'b0;
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end

    // Two-stage read: registered physical address, then registered RAM output
    always_ff @(posedge clk_hs or negedge rst_hs) begin
        if (!rst_hs) begin
            rd_pend  <= 1'b0;
            rd_zero  <= 1'b0;
            rd_phys  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_pend  <= rd_en;
            rd_valid <= rd_pend;
            if (rd_en) begin
                rd_phys <= rd_phys_c;
                rd_zero <= rd_oob_c;
            end
            if (rd_pend) begin
                rd_data <= rd_zero ? '0 : mem[rd_phys];
            end
        end
    end

endmodule

// File: tb/tb_fm_spy_capture.sv
// Bench for fm_spy_capture (DEPTH=16): directed scenarios plus randomized traffic checked
// against a word-log reference model of the capture window.
module tb_fm_spy_capture;

    logic        clk_hs = 1'b0;
    logic        rst_hs = 1'b0;
    logic [31:0] data_in = '0;
    logic        data_valid = 1'b0;
    logic        arm = 1'b0;
    logic        trigger = 1'b0;
    logic        freeze_req = 1'b0;
    logic [3:0]  post_count = '0;
    logic        rd_en = 1'b0;
    logic [3:0]  rd_addr = '0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [1:0]  state;
    logic        triggered;
    logic [3:0]  trig_index;
    logic [4:0]  fill_count;

    int n_vec = 0;
    int n_err = 0;

    fm_spy_capture #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
        .clk_hs(clk_hs), .rst_hs(rst_hs), .data_in(data_in), .data_valid(data_valid),
        .arm(arm), .trigger(trigger), .freeze_req(freeze_req), .post_count(post_count),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .state(state), .triggered(triggered), .trig_index(trig_index), .fill_count(fill_count)
    );

    always #5 clk_hs = ~clk_hs;

    // Reference model: log of captured words (last 16 kept), absolute trigger position
    int          m_st;
    int          m_n;
    int          m_trig_abs;
    int          m_post_left;
    bit          m_pending;
    bit          m_triggered;
    logic [3:0]  m_trig_index;
    logic [31:0] m_q[$];
    bit          s1_v, s1_coh, o_v, o_coh;
    logic [31:0] s1_d, o_d;

    task automatic model_reset();
        m_st = 0; m_n = 0; m_trig_abs = 0; m_post_left = 0;
        m_pending = 0; m_triggered = 0; m_trig_index = '0; m_q.delete();
        s1_v = 0; s1_coh = 0; o_v = 0; o_coh = 0; s1_d = '0; o_d = '0;
    endtask

    task automatic model_freeze();
        int oldest;
        oldest = (m_n > 16) ? m_n - 16 : 0;
        m_st = 3;
        m_triggered = 1;
        m_trig_index = 4'((((m_trig_abs - oldest) % 16) + 16) % 16);
    endtask

    task automatic model_step();
        bit tw = 0;
        bit post_active;
        o_v = s1_v;
        if (s1_v) begin
            o_d = s1_d;
            o_coh = s1_coh;
        end
        s1_v   = rd_en;
        s1_coh = (m_st == 3) || (m_q.size() == 0);
        s1_d   = (int'(rd_addr) < m_q.size()) ? m_q[rd_addr] : 32'h0;
        post_active = (m_st == 2) && !m_pending;
        case (m_st)
            0: if (arm) m_st = 1;
            1, 2: begin
                if (freeze_req) begin
                    m_st = 3; m_triggered = 0; m_pending = 0;
                end else begin
                    if (data_valid) begin
                        m_q.push_back(data_in);
                        if (m_q.size() > 16) void'(m_q.pop_front());
                        m_n++;
                    end
                    if (m_st == 1 && trigger) begin
                        m_post_left = int'(post_count);
                        if (data_valid) tw = 1;
                        else begin m_pending = 1; m_st = 2; end
                    end else if (m_st == 2 && m_pending && data_valid) begin
                        tw = 1;
                    end
                    if (tw) begin
                        m_trig_abs = m_n - 1;
                        m_pending = 0;
                        if (m_post_left == 0) model_freeze();
                        else m_st = 2;
                    end else if (post_active && data_valid) begin
                        m_post_left--;
                        if (m_post_left == 0) model_freeze();
                    end
                end
            end
            default: if (arm) begin
                m_st = 1; m_n = 0; m_q.delete(); m_triggered = 0;
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clk_hs);
        model_step();
        #1;
    endtask

    task automatic step(input bit dv, input logic [31:0] d, input bit a, input bit t, input bit f);
        data_valid = dv; data_in = d; arm = a; trigger = t; freeze_req = f;
        tick();
        data_valid = 0; arm = 0; trigger = 0; freeze_req = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk_hs);
        #1;
        n_vec++; if (state !== 2'b00) begin n_err++; $display("FAIL reset_state: got %0h exp 0", state); end
        n_vec++; if (fill_count !== 5'd0) begin n_err++; $display("FAIL reset_fill: got %0d exp 0", fill_count); end
        n_vec++; if (triggered !== 1'b0) begin n_err++; $display("FAIL reset_trig: got %0b exp 0", triggered); end
        n_vec++; if (trig_index !== 4'd0) begin n_err++; $display("FAIL reset_tidx: got %0d exp 0", trig_index); end
        n_vec++; if (rd_valid !== 1'b0 || rd_data !== 32'h0) begin n_err++; $display("FAIL reset_rd: got %0b/%0h exp 0/0", rd_valid, rd_data); end
        rst_hs = 1'b1;
        model_reset();
    endtask

    task automatic test_freeze_req();
        logic [31:0] e;
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 32'hA0 + 32'(i), 0, 0, 0);
        step(0, 0, 0, 0, 1);
        n_vec++; if (state !== 2'b11) begin n_err++; $display("FAIL frz_state: got %0h exp 3", state); end
        n_vec++; if (fill_count !== 5'd5) begin n_err++; $display("FAIL frz_fill: got %0d exp 5", fill_count); end
        n_vec++; if (triggered !== 1'b0) begin n_err++; $display("FAIL frz_trig: got %0b exp 0", triggered); end
        for (int i = 0; i <= 6; i++) begin
            rd_en = (i < 6);
            rd_addr = (i < 5) ? 4'(i) : 4'd7;
            tick();
            if (i > 0) begin
                e = (i - 1 < 5) ? 32'hA0 + 32'(i - 1) : 32'h0;
                n_vec++; if (rd_valid !== 1'b1 || rd_data !== e) begin
                    n_err++; $display("FAIL frz_read%0d: got %0b/%0h exp 1/%0h", i - 1, rd_valid, rd_data, e);
                end
            end
        end
        rd_en = 0;
        tick();
        n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL frz_rd_idle: got %0b exp 0", rd_valid); end
    endtask

    task automatic test_wrap_trigger();
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 20; i++) step(1, 32'(i), 0, 0, 0);
        post_count = 4'd3;
        step(1, 32'd20, 0, 1, 0);
        step(1, 32'd21, 0, 0, 0);
        step(1, 32'd22, 0, 0, 0);
        n_vec++; if (state !== 2'b10) begin n_err++; $display("FAIL wrap_post: got %0h exp 2", state); end
        step(1, 32'd23, 0, 0, 0);
        n_vec++; if (state !== 2'b11) begin n_err++; $display("FAIL wrap_state: got %0h exp 3", state); end
        n_vec++; if (fill_count !== 5'd16) begin n_err++; $display("FAIL wrap_fill: got %0d exp 16", fill_count); end
        n_vec++; if (triggered !== 1'b1) begin n_err++; $display("FAIL wrap_trig: got %0b exp 1", triggered); end
        n_vec++; if (trig_index !== 4'd12) begin n_err++; $display("FAIL wrap_tidx: got %0d exp 12", trig_index); end
        rd_en = 1; rd_addr = 4'd0; tick();
        rd_addr = 4'd15; tick();
        n_vec++; if (rd_valid !== 1'b1 || rd_data !== 32'd8) begin n_err++; $display("FAIL wrap_rd0: got %0b/%0h exp 1/8", rd_valid, rd_data); end
        rd_en = 0; tick();
        n_vec++; if (rd_valid !== 1'b1 || rd_data !== 32'd23) begin n_err++; $display("FAIL wrap_rd15: got %0b/%0h exp 1/17", rd_valid, rd_data); end
        tick();
    endtask

    task automatic test_late_trigger();
        step(0, 0, 1, 0, 0);
        post_count = 4'd2;
        step(0, 0, 0, 1, 0);
        n_vec++; if (state !== 2'b10 || fill_count !== 5'd0) begin n_err++; $display("FAIL late_pend: got %0h/%0d exp 2/0", state, fill_count); end
        step(1, 32'h11, 0, 0, 0);
        step(1, 32'h22, 0, 0, 0);
        n_vec++; if (state !== 2'b10) begin n_err++; $display("FAIL late_post: got %0h exp 2", state); end
        step(1, 32'h33, 0, 0, 0);
        n_vec++; if (state !== 2'b11 || fill_count !== 5'd3) begin n_err++; $display("FAIL late_frz: got %0h/%0d exp 3/3", state, fill_count); end
        n_vec++; if (triggered !== 1'b1 || trig_index !== 4'd0) begin n_err++; $display("FAIL late_tidx: got %0b/%0d exp 1/0", triggered, trig_index); end
        rd_en = 1; rd_addr = 4'd0; tick();
        rd_en = 0; tick();
        n_vec++; if (rd_valid !== 1'b1 || rd_data !== 32'h11) begin n_err++; $display("FAIL late_rd0: got %0b/%0h exp 1/11", rd_valid, rd_data); end
    endtask

    task automatic test_rearm_post0();
        step(0, 0, 1, 0, 0);
        n_vec++; if (state !== 2'b01 || fill_count !== 5'd0 || triggered !== 1'b0) begin
            n_err++; $display("FAIL rearm: got st=%0h fill=%0d trig=%0b exp 1/0/0", state, fill_count, triggered);
        end
        post_count = 4'd0;
        step(1, 32'h5A, 0, 1, 0);
        n_vec++; if (state !== 2'b11 || fill_count !== 5'd1) begin n_err++; $display("FAIL post0_frz: got %0h/%0d exp 3/1", state, fill_count); end
        n_vec++; if (triggered !== 1'b1 || trig_index !== 4'd0) begin n_err++; $display("FAIL post0_tidx: got %0b/%0d exp 1/0", triggered, trig_index); end
        rd_en = 1; rd_addr = 4'd0; tick();
        rd_en = 0; tick();
        n_vec++; if (rd_valid !== 1'b1 || rd_data !== 32'h5A) begin n_err++; $display("FAIL post0_rd0: got %0b/%0h exp 1/5a", rd_valid, rd_data); end
    endtask

    task automatic test_freeze_wins();
        step(0, 0, 1, 0, 0);
        step(1, 32'h1, 0, 0, 0);
        step(1, 32'h2, 0, 0, 0);
        post_count = 4'd1;
        step(1, 32'h3, 0, 1, 1);
        n_vec++; if (state !== 2'b11 || fill_count !== 5'd2) begin n_err++; $display("FAIL fwin_frz: got %0h/%0d exp 3/2", state, fill_count); end
        n_vec++; if (triggered !== 1'b0) begin n_err++; $display("FAIL fwin_trig: got %0b exp 0", triggered); end
        step(1, 32'h4, 0, 0, 0);
        n_vec++; if (fill_count !== 5'd2) begin n_err++; $display("FAIL fwin_nowr: got %0d exp 2", fill_count); end
        rd_en = 1; rd_addr = 4'd1; tick();
        rd_addr = 4'd2; tick();
        n_vec++; if (rd_valid !== 1'b1 || rd_data !== 32'h2) begin n_err++; $display("FAIL fwin_rd1: got %0b/%0h exp 1/2", rd_valid, rd_data); end
        rd_en = 0; tick();
        n_vec++; if (rd_valid !== 1'b1 || rd_data !== 32'h0) begin n_err++; $display("FAIL fwin_rd2: got %0b/%0h exp 1/0", rd_valid, rd_data); end
    endtask

    task automatic test_async_reset();
        step(0, 0, 1, 0, 0);
        post_count = 4'd2;
        step(1, 32'h70, 0, 1, 0);
        step(1, 32'h71, 0, 0, 0);
        n_vec++; if (state !== 2'b10) begin n_err++; $display("FAIL arst_pre: got %0h exp 2", state); end
        rd_en = 1; rd_addr = 4'd0; tick();
        rd_en = 0;
        #2 rst_hs = 1'b0;
        #1;
        model_reset();
        n_vec++; if (state !== 2'b00 || fill_count !== 5'd0) begin n_err++; $display("FAIL arst_now: got %0h/%0d exp 0/0", state, fill_count); end
        n_vec++; if (rd_valid !== 1'b0 || triggered !== 1'b0) begin n_err++; $display("FAIL arst_rd: got %0b/%0b exp 0/0", rd_valid, triggered); end
        @(posedge clk_hs);
        #1 rst_hs = 1'b1;
        tick();
        n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL arst_drop: got %0b exp 0", rd_valid); end
        step(0, 0, 1, 0, 0);
        step(1, 32'h77, 0, 0, 0);
        n_vec++; if (state !== 2'b01 || fill_count !== 5'd1) begin n_err++; $display("FAIL arst_rearm: got %0h/%0d exp 1/1", state, fill_count); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            data_valid = ($urandom_range(0, 9) < 7);
            data_in    = $urandom();
            arm        = ($urandom_range(0, 31) == 0);
            trigger    = ($urandom_range(0, 24) == 0);
            freeze_req = ($urandom_range(0, 99) == 0);
            post_count = 4'($urandom_range(0, 15));
            rd_en      = ($urandom_range(0, 2) == 0);
            rd_addr    = 4'($urandom_range(0, 15));
            tick();
            n_vec++; if (state !== 2'(m_st)) begin n_err++; $display("FAIL rnd_state c%0d: got %0h exp %0h", c, state, m_st); end
            n_vec++; if (fill_count !== 5'(m_q.size())) begin n_err++; $display("FAIL rnd_fill c%0d: got %0d exp %0d", c, fill_count, m_q.size()); end
            n_vec++; if (triggered !== m_triggered) begin n_err++; $display("FAIL rnd_trig c%0d: got %0b exp %0b", c, triggered, m_triggered); end
            if (m_triggered) begin
                n_vec++; if (trig_index !== m_trig_index) begin n_err++; $display("FAIL rnd_tidx c%0d: got %0d exp %0d", c, trig_index, m_trig_index); end
            end
            n_vec++; if (rd_valid !== o_v) begin n_err++; $display("FAIL rnd_rdv c%0d: got %0b exp %0b", c, rd_valid, o_v); end
            if (o_v && o_coh) begin
                n_vec++; if (rd_data !== o_d) begin n_err++; $display("FAIL rnd_rdd c%0d: got %0h exp %0h", c, rd_data, o_d); end
            end
        end
        data_valid = 0; arm = 0; trigger = 0; freeze_req = 0; rd_en = 0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        step(0, 0, 0, 0, 1);
        n_vec++; if (state !== 2'b11) begin n_err++; $display("FAIL b2b_state: got %0h exp 3", state); end
        for (int i = 0; i <= 16; i++) begin
            rd_en = (i < 16);
            rd_addr = 4'(i);
            tick();
            if (i > 0) begin
                e = (i - 1 < m_q.size()) ? m_q[i - 1] : 32'h0;
                n_vec++; if (rd_valid !== 1'b1 || rd_data !== e) begin
                    n_err++; $display("FAIL b2b_rd%0d: got %0b/%0h exp 1/%0h", i - 1, rd_valid, rd_data, e);
                end
            end
        end
        rd_en = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_freeze_req();
        test_wrap_trigger();
        test_late_trigger();
        test_rearm_post0();
        test_freeze_wins();
        test_async_reset();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
